// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, fetches from combinational imem, queues {pc, instr} for decode (1-cycle fetch-to-valid).
// Backpressure: fetch stalls and PC holds when the queue is full and decode is not popping; halt and fault also stall.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_en_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        fault_o
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [31:0]   q_instr_q [QDEPTH];
  logic          pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign valid_o     = (count_q != '0);
  assign pop         = valid_o && ready_i;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign push        = !rst_i && !fault_q && !halt_i && !redirect_i && ((count_q < FULL) || pop);
  assign imem_en_o   = push;
  assign imem_addr_o = pc_q;
  assign instr_o     = valid_o ? q_instr_q[rd_ptr_q] : NOP_INSTR;
  assign pc_o        = valid_o ? q_pc_q[rd_ptr_q] : 32'h0;
  assign fault_o     = fault_q;

  always_comb begin
    pc_d     = pc_q;
    fault_d  = fault_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      // Redirect flushes everything, including a pop offered this cycle.
      pc_d     = redirect_pc_i;
      fault_d  = |redirect_pc_i[1:0];
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        pc_d     = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc_q[wr_ptr_q]    <= pc_q;
      q_instr_q[wr_ptr_q] <= imem_instr_i;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Random + directed bench for instruction_fetch_unit; an expected-entry queue is filled by the driver and drained by a monitor.
module tb_instruction_fetch_unit;
  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_o;
  logic        imem_en_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        fault_o;

  always #5 clk_i = ~clk_i;

  instruction_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .imem_addr_o(imem_addr_o), .imem_en_o(imem_en_o),
    .imem_instr_i(imem_instr_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o),
    .ready_i(ready_i), .fault_o(fault_o)
  );

  // Memory contents are an address-derived pattern; word at 0 is 0x00500093.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'h0050_0093;
  endfunction
  assign imem_instr_i = mem_word(imem_addr_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_pc    = RPC;
  logic        m_fault = 1'b0;
  logic        m_en    = 1'b0;
  int          checks  = 0;
  int          errors  = 0;
  int          n_pops  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle and retires accepted entries.
  initial begin
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      chk("valid_o", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("pc_o", pc_o, exp_q[0].pc);
        chk("instr_o", instr_o, exp_q[0].instr);
      end else begin
        chk("pc_o_empty", pc_o, 32'h0);
        chk("instr_o_empty", instr_o, NOP);
      end
      chk("fault_o", {31'b0, fault_o}, {31'b0, m_fault});
      chk("imem_en_o", {31'b0, imem_en_o}, {31'b0, m_en});
      chk("imem_addr_o", imem_addr_o, m_pc);
      if (!rst_i && !redirect_i && ready_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
    end
  end

  // Driver: sets inputs after each rising edge, then advances the model for the next edge.
  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0; ready_i = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk_i); #1;
      rst_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; ready_i = 1'b1;
      if (cyc < 3)                     rst_i = 1'b1;
      else if (cyc >= 13 && cyc < 18)  ready_i = 1'b0;
      else if (cyc == 26)              begin redirect_i = 1'b1; redirect_pc_i = 32'h40; end
      else if (cyc == 30)              begin redirect_i = 1'b1; redirect_pc_i = 32'h42; end
      else if (cyc == 41)              begin redirect_i = 1'b1; redirect_pc_i = 32'h80; end
      else if (cyc >= 45 && cyc < 48)  halt_i = 1'b1;
      else if (cyc == 55)              begin redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8; end
      else if (cyc == 62)              begin ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h7; end
      else if (cyc == 66)              rst_i = 1'b1;
      else if (cyc >= 80) begin
        ready_i    = ($urandom % 4) != 0;
        halt_i     = ($urandom % 8) == 0;
        redirect_i = ($urandom % 16) == 0;
        rst_i      = ($urandom % 200) == 0;
        redirect_pc_i = {22'($urandom), 8'($urandom_range(0, 255)), 2'b00};
        if (($urandom % 4) == 0) redirect_pc_i[1:0] = 2'($urandom_range(1, 3));
      end
      m_en = !rst_i && !m_fault && !halt_i && !redirect_i &&
             (exp_q.size() < QD || (exp_q.size() != 0 && ready_i));
      @(negedge clk_i); #1;
      if (rst_i) begin
        exp_q.delete();
        m_pc = RPC; m_fault = 1'b0;
      end else if (redirect_i) begin
        exp_q.delete();
        m_pc = redirect_pc_i; m_fault = redirect_pc_i[1:0] != 2'b00;
      end else if (m_en) begin
        exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1; redirect_i = 1'b0; halt_i = 1'b0;
    @(negedge clk_i); #2;
    checks++;
    if (n_pops < 300) begin
      errors++;
      $display("FAIL pop_count: got %0d expected at least 300", n_pops);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
